// File: rtl/arm_decoder.sv
// ARM instruction decoder: classifies a fetched word, extracts register and immediate
// fields, and buffers decoded entries in a 2-deep in-order FIFO with valid/ready on both sides.
package cpu_types_pkg;
    typedef enum logic [4:0] {
        DATAPROC_IMM     = 5'd0,
        DATAPROC_REG_IMM = 5'd1,
        DATAPROC_REG_REG = 5'd2,
        LOAD             = 5'd3,
        STORE            = 5'd4,
        LDR_STR_HALF_IMM = 5'd5,
        LDR_STR_HALF_REG = 5'd6,
        LDM_STM          = 5'd7,
        BRANCH           = 5'd8,
        BRANCH_LINK      = 5'd9,
        BRANCH_EX        = 5'd10,
        SWI              = 5'd11,
        MULTIPLY         = 5'd12,
        MULTIPLY_LONG    = 5'd13,
        SWAP             = 5'd14,
        MRS              = 5'd15,
        MSR              = 5'd16,
        UNDEF            = 5'd17,
        EXCEPTION        = 5'd18
    } instr_type_t;

    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef struct packed {
        instr_type_t instr_type;
        logic [3:0]  cond;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic [23:0] immediate;
    } decoded_word_t;
endpackage

module arm_decoder
    import cpu_types_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic                in_abort,
    output logic                out_valid,
    input  logic                out_ready,
    output decoded_word_t       out_decoded,
    output logic [PC_WIDTH-1:0] out_pc
);
    // Handshake: a side transfers on a cycle where valid && ready at the rising edge;
    // flush discards the transfer on both sides in that cycle.

    logic [31:0]   ir;
    instr_type_t   dec_type;
    logic [23:0]   dec_imm;
    decoded_word_t dec;

    assign ir = in_instr;

    // First matching rule wins; the condition field is carried, never evaluated.
    always_comb begin
        dec_type = UNDEF;
        if (in_abort)
            dec_type = EXCEPTION;
        else if (ir[27:4] == 24'h12FFF1)
            dec_type = BRANCH_EX;
        else if (ir[27:25] == 3'b101)
            dec_type = ir[24] ? BRANCH_LINK : BRANCH;
        else if (ir[27:24] == 4'b1111)
            dec_type = SWI;
        else if (ir[27:22] == 6'b000000 && ir[7:4] == 4'b1001)
            dec_type = MULTIPLY;
        else if (ir[27:23] == 5'b00001 && ir[7:4] == 4'b1001)
            dec_type = MULTIPLY_LONG;
        else if (ir[27:23] == 5'b00010 && ir[21:20] == 2'b00 && ir[11:4] == 8'h09)
            dec_type = SWAP;
        else if (ir[27:25] == 3'b000 && ir[7] && ir[4] && ir[6:5] != 2'b00)
            dec_type = ir[22] ? LDR_STR_HALF_IMM : LDR_STR_HALF_REG;
        else if (ir[27:23] == 5'b00010 && ir[21:16] == 6'b001111 && ir[11:0] == 12'h000)
            dec_type = MRS;
        else if (ir[27:26] == 2'b00 && ir[24:23] == 2'b10 && ir[21:20] == 2'b10
                 && ir[15:12] == 4'hF)
            dec_type = MSR;
        else if (ir[27:25] == 3'b011 && ir[4])
            dec_type = UNDEF;
        else if (ir[27:26] == 2'b01)
            dec_type = ir[20] ? LOAD : STORE;
        else if (ir[27:25] == 3'b100)
            dec_type = LDM_STM;
        else if (ir[27:26] == 2'b00) begin
            if (ir[25])
                dec_type = DATAPROC_IMM;
            else if (!ir[4])
                dec_type = DATAPROC_REG_IMM;
            else if (!ir[7])
                dec_type = DATAPROC_REG_REG;
            else
                dec_type = UNDEF;
        end
    end

    always_comb begin
        dec_imm = ir[23:0];
        case (dec_type)
            DATAPROC_IMM:     dec_imm = {7'b0, ir[24:20], ir[11:0]};
            DATAPROC_REG_IMM: dec_imm = {12'b0, ir[24:20], ir[11:5]};
            DATAPROC_REG_REG: dec_imm = {17'b0, ir[24:20], ir[6:5]};
            LOAD, STORE:      dec_imm = {7'b0, ~ir[25], ~ir[24], ir[23:21], ir[11:0]};
            LDR_STR_HALF_IMM: dec_imm = {16'b0, ir[11:8], ir[3:0]};
            LDM_STM:          dec_imm = {8'b0, ir[15:0]};
            MSR:              dec_imm = ir[25] ? {12'b0, ir[11:0]} : ir[23:0];
            EXCEPTION:        dec_imm = 24'h0;
            default:          dec_imm = ir[23:0];
        endcase
    end

    always_comb begin
        dec.instr_type = dec_type;
        dec.cond       = ir[31:28];
        dec.rd         = ir[15:12];
        dec.rn         = ir[19:16];
        dec.rm         = ir[3:0];
        dec.rs         = ir[11:8];
        dec.immediate  = dec_imm;
    end

    decoded_word_t       mem_dec [2];
    logic [PC_WIDTH-1:0] mem_pc  [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;
    logic [1:0]          count_next;
    logic                not_full;
    logic                push;
    logic                pop;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        count_next = count + {1'b0, push} - {1'b0, pop};
    end

    // not_full is registered so in_ready never depends on out_ready within a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            not_full   <= 1'b1;
            mem_dec[0] <= '0;
            mem_dec[1] <= '0;
            mem_pc[0]  <= '0;
            mem_pc[1]  <= '0;
        end else if (flush) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            not_full <= 1'b1;
        end else begin
            if (push) begin
                mem_dec[wr_ptr] <= dec;
                mem_pc[wr_ptr]  <= in_pc;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count    <= count_next;
            not_full <= (count_next != 2'd2);
        end
    end

    assign in_ready    = not_full && !rst;
    assign out_valid   = (count != 2'd0);
    assign out_decoded = mem_dec[rd_ptr];
    assign out_pc      = mem_pc[rd_ptr];

endmodule

// File: doc/arm_decoder.md
ARM_DECODER -- requirements
Module: arm_decoder

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, the width of the instruction address carried alongside each instruction.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port flush  input  1  synchronous discard of all buffered and incoming instructions.
REQ-005 SHALL have port in_valid  input  1  a fetched instruction is offered.
REQ-006 SHALL have port in_ready  output  1  the decoder accepts the offer this cycle.
REQ-007 SHALL have port in_instr  input  32  raw ARM instruction word (ir).
REQ-008 SHALL have port in_pc  input  PC_WIDTH  address of in_instr.
REQ-009 SHALL have port in_abort  input  1  the fetch returned a prefetch abort.
REQ-010 SHALL have port out_valid  output  1  out_decoded and out_pc hold a valid entry.
REQ-011 SHALL have port out_ready  input  1  the consumer takes the entry this cycle.
REQ-012 SHALL have port out_decoded  output  49  cpu_types_pkg::decoded_word_t.
REQ-013 SHALL have port out_pc  output  PC_WIDTH  address of the decoded entry.

Function
REQ-014 SHALL accept an input when in_valid&&in_ready, and SHALL present an output transfer when out_valid&&out_ready.
REQ-015 SHALL buffer decoded entries in a 2-entry in-order FIFO; in_ready SHALL equal (count<2), driven from a register, with no combinational path from out_ready.
REQ-016 SHALL present an accepted entry on out_valid the cycle after acceptance (1-cycle latency) and SHALL sustain 1 entry/cycle when out_ready is held high.
REQ-017 A simultaneous push and pop at count==2 SHALL NOT occur, because in_ready is 0; at count 1, a simultaneous push and pop SHALL leave count at 1.
REQ-018 While out_valid=1 and out_ready=0, out_decoded and out_pc SHALL hold stable.
REQ-019 On flush, count SHALL become 0 next cycle, and an input accepted in the flush cycle SHALL be discarded; flush SHALL dominate push and pop.
REQ-020 Fields: condition=ir[31:28], Rd=ir[15:12], Rn=ir[19:16], Rm=ir[3:0], Rs=ir[11:8].
REQ-021 SHALL classify instr_type using the first match in this priority order:
 - in_abort: EXCEPTION
 - ir[27:4]==24'h12FFF1: BRANCH_EX
 - ir[27:25]==101: ir[24] ? BRANCH_LINK : BRANCH
 - ir[27:24]==1111: SWI
 - ir[27:22]==000000 & ir[7:4]==1001: MULTIPLY
 - ir[27:23]==00001 & ir[7:4]==1001: MULTIPLY_LONG
 - ir[27:23]==00010 & ir[21:20]==00 & ir[11:4]==8'h09: SWAP
 - ir[27:25]==000 & ir[7]&ir[4] & ir[6:5]!=00: ir[22] ? LDR_STR_HALF_IMM : LDR_STR_HALF_REG
 - ir[27:23]==00010 & ir[21:16]==001111 & ir[11:0]==0: MRS
 - ir[27:26]==00 & ir[24:23]==10 & ir[21:20]==10 & ir[15:12]==1111: MSR
 - ir[27:25]==011 & ir[4]: UNDEF
 - ir[27:26]==01: ir[20] ? LOAD : STORE
 - ir[27:25]==100: LDM_STM
 - ir[27:26]==00: ir[25] ? DATAPROC_IMM : (!ir[4] ? DATAPROC_REG_IMM : (!ir[7] ? DATAPROC_REG_REG : UNDEF))
 - otherwise (coprocessor): UNDEF.
REQ-022 SHALL pack immediate (24 bits) as follows:
 - DATAPROC_IMM: {7'b0,ir[24:20],ir[11:0]}
 - DATAPROC_REG_IMM: {12'b0,ir[24:20],ir[11:5]}
 - DATAPROC_REG_REG: {17'b0,ir[24:20],ir[6:5]}
 - LOAD/STORE: {7'b0,~ir[25],~ir[24],ir[23:21],ir[11:0]}
 - LDR_STR_HALF_IMM: {16'b0,ir[11:8],ir[3:0]}
 - LDM_STM: {8'b0,ir[15:0]}
 - MSR with ir[25]=1: {12'b0,ir[11:0]}
 - EXCEPTION: 0
 - all others: ir[23:0].
REQ-023 Decode SHALL be combinational on the input side and registered into the FIFO; the condition field SHALL NOT be evaluated (COND_NV passes through unchanged).

Reset
REQ-024 While rst=1: count=0, in_ready=0, out_valid=0, out_decoded=0, out_pc=0.
REQ-025 In the first cycle after rst deasserts, in_ready SHALL be 1.
REQ-026 A reset asserted mid-stream SHALL drop all buffered entries immediately, with no partial output.

Verification
REQ-027 Push 0xE3A01005 (MOV r1,#5) -> next cycle out_valid=1, type DATAPROC_IMM, cond AL, Rd=1, Rn=0, immediate=0x01A005.
REQ-028 Push 0xE12FFF1E, then 0xEAFFFFFE -> BRANCH_EX with Rm=14, then BRANCH with immediate=0xFFFFFE, on consecutive cycles.
REQ-029 Push 0xE5912004 (LDR r2,[r1,#4]) -> LOAD, Rd=2, Rn=1, immediate=0x014004.
REQ-030 out_ready=0, offer 3 instructions -> two accepted, then in_ready=0; release out_ready -> the entries drain in order, with no loss or duplication.
REQ-031 count=2 plus flush, with in_valid=1 in the same cycle -> next cycle out_valid=0, count=0, and the concurrent input is never output.
REQ-032 in_abort=1 with any in_instr -> EXCEPTION with immediate=0; rst pulse while count=2 -> out_valid=0 in the same cycle.
